ap_ctrl_driver: RTL
===================

Name: ap_ctrl_driver

Overview:
- Synthesizable initiator for the HLS block-level control handshake: it drives ap_start and ap_continue and consumes ap_ready and ap_done, which is the opposite end of the module-status monitoring we already run.
- Issues a programmed number of transactions to one HLS kernel, with up to MAX_OUTSTANDING started-but-not-done transactions in flight.
- Applies configurable ap_continue back-pressure.
- Records latency and start-interval statistics on-chip, for hardware bring-up of kernels without a testbench.

Parameters:
- CNT_W, 32, width of transaction counters, cycle timestamp and latency/interval results.
- MAX_OUTSTANDING, 4, depth of the in-flight timestamp FIFO (power of 2, >=1).
- HOLD_W, 8, width of the ap_continue hold-off count.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_start  in  1  one-cycle pulse that launches a run.
- cfg_num_txn  in  CNT_W  number of transactions, sampled on accepted cfg_start.
- cfg_continue_hold  in  HOLD_W  cycles to delay ap_continue after ap_done, sampled on accepted cfg_start.
- ap_start  out  1  start request to the kernel.
- ap_ready  in  1  kernel accepted the start.
- ap_done  in  1  kernel output complete.
- ap_continue  out  1  driver consumes ap_done.
- busy  out  1  high from accepted cfg_start until the run completes.
- all_done  out  1  one-cycle pulse at run completion.
- txn_started  out  CNT_W  starts accepted this run.
- txn_done  out  CNT_W  dones consumed this run.
- last_latency  out  CNT_W  latency of the most recent consumed transaction.
- max_latency  out  CNT_W  maximum latency this run.
- min_interval  out  CNT_W  minimum cycles between consecutive accepted starts.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - ap_start, ap_continue, busy, all_done, err = 0.
  - All counters and statistics = 0, except min_interval = all-ones.
  - FSM = IDLE; FIFO empty; cycle counter = 0.
- cyc: free-running CNT_W counter.
  - Latency = cyc_at_done - ts (modulo 2^CNT_W), so wrap-around is handled.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_start with cfg_num_txn == 0: pulse all_done next cycle; busy stays 0.
  - cfg_start with cfg_num_txn > 0: clear counters, statistics and err; go to RUN.
  - cfg_start while busy is ignored.
- RUN:
  - ap_start is registered, high while txn_started < num and FIFO not full.
  - Timestamp = cyc in the first cycle ap_start is high for that transaction.
  - Start accepted on the cycle ap_start && ap_ready.
    - Push the timestamp; increment txn_started.
    - Update min_interval from the previous acceptance (skip for the first).
  - ap_start deasserts the cycle after the acceptance that brings txn_started to num, or that fills the FIFO.
  - ap_start must never drop before ap_ready is seen.
  - When txn_started == num, go to DRAIN.
- DRAIN:
  - No starts issued.
  - When txn_done == num, go to IDLE, pulse all_done and drop busy in the same cycle.
- ap_continue (RUN and DRAIN):
  - Hold-off counter hc; ap_continue = busy && hc == 0.
  - When ap_done is high and ap_continue is low, with hc idle, load hc = cfg_continue_hold and count down.
  - With hold = 0, ap_continue stays high and done is consumed in the same cycle.
  - After each consume, hc reloads on the next ap_done.
- Done consumed on the cycle ap_done && ap_continue:
  - Pop the FIFO, compute latency, update last_latency and max_latency, increment txn_done.
- Simultaneous accept and consume in the same cycle: push and pop both take effect; occupancy is unchanged.
  - A full FIFO with a simultaneous pop does not allow a same-cycle accept, because ap_start was already low.
- Error cases:
  - ap_done consumed with the FIFO empty: set err, do not pop, no counter update.
  - ap_ready without ap_start: set err.
- Reset mid-run: all state returns to reset values immediately; ap_start drops asynchronously.

Decomposition:
- Package ap_ctrl_driver_pkg: FSM state enum (IDLE/RUN/DRAIN) and the latency-compute function.
- One sub-module: ts_fifo, a synchronous FIFO of CNT_W × MAX_OUTSTANDING.
  - Ports: push, pop, din, dout, full, empty.
  - Registered pointers with an extra wrap bit.

Test Plan:
- Kernel ready immediately, done 10 cycles after accept, num=1, hold=0 -> ap_start high 1 cycle; txn_done=1; last_latency=max_latency=10; all_done pulses; err=0.
- num=8, kernel interval 3, latency 20, MAX_OUTSTANDING=4 -> never more than 4 in flight; min_interval=3; txn_started=txn_done=8; max_latency=20.
- hold=5, num=2 -> ap_continue low for exactly 5 cycles after each ap_done rises; kernel holds ap_done; both consumed; latency includes the 5-cycle hold.
- cfg_num_txn=0 -> all_done one cycle later; busy never asserts; ap_start stays 0.
- Spurious ap_done with no transaction outstanding -> err=1 sticky; txn_done unchanged; next cfg_start clears err.
- Preload cyc near 2^32-4, latency 10 -> last_latency=10 across wrap; assert reset mid-run -> ap_start=0 and busy=0 asynchronously.

Source files
------------

// File: rtl/ap_ctrl_driver_pkg.sv
// ap_ctrl_driver_pkg
// Shared types and helpers for the HLS block-level control initiator.
//   state_e       : run-level FSM state (IDLE / RUN / DRAIN)
//   latency_calc  : modular difference between a completion cycle and a
//                   start timestamp; callers truncate the result to their
//                   counter width, so wrap-around of the cycle counter is
//                   absorbed naturally.
package ap_ctrl_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Widest counter the latency helper supports.
  localparam int LAT_CALC_W = 64;

  function automatic logic [LAT_CALC_W-1:0] latency_calc(
    input logic [LAT_CALC_W-1:0] now_cyc,
    input logic [LAT_CALC_W-1:0] ts
  );
    return now_cyc - ts;
  endfunction

endpackage

// File: rtl/ap_ctrl_driver_ts_fifo.sv
// ts_fifo
// Start-timestamp FIFO holding one entry per in-flight kernel transaction.
// The head entry is readable in the same cycle it is popped, so the
// consumer can compute latency on the consume cycle itself.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   push, din    : write din when push && !full
//   pop, dout    : advance head when pop && !empty; dout is the head entry
//   full, empty  : occupancy flags
module ts_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra pointer bit distinguishes full from empty.
  localparam int PW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;

  generate
    if (DEPTH > 1) begin : g_idx
      assign widx = wptr_q[AW-1:0];
      assign ridx = rptr_q[AW-1:0];
    end else begin : g_single
      assign widx = '0;
      assign ridx = '0;
    end
  endgenerate

  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q - rptr_q) == PW'(DEPTH));
  assign dout  = mem_q[ridx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop && !empty) begin
        rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_q[widx] <= din;
    end
  end

endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver
// Initiator side of the HLS ap_ctrl handshake. Issues a programmed number
// of transactions to one kernel with bounded outstanding starts, applies a
// programmable ap_continue hold-off, and records latency / start-interval
// statistics for bring-up.
// Ports:
//   clock, reset                  : clock, asynchronous active-high reset
//   cfg_start                     : pulse that launches a run (ignored while busy)
//   cfg_num_txn, cfg_continue_hold: run parameters sampled with cfg_start
//   ap_start / ap_ready           : start request and kernel acceptance
//   ap_done / ap_continue         : kernel completion and its consumption
//   busy, all_done                : run active level and completion pulse
//   txn_started, txn_done         : accepted starts / consumed dones this run
//   last_latency, max_latency     : start-to-consume latency statistics
//   min_interval                  : minimum cycles between accepted starts
//   err                           : sticky protocol error
module ap_ctrl_driver
  import ap_ctrl_driver_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int HOLD_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_num_txn,
  input  logic [HOLD_W-1:0] cfg_continue_hold,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  output logic              ap_continue,
  output logic              busy,
  output logic              all_done,
  output logic [CNT_W-1:0]  txn_started,
  output logic [CNT_W-1:0]  txn_done,
  output logic [CNT_W-1:0]  last_latency,
  output logic [CNT_W-1:0]  max_latency,
  output logic [CNT_W-1:0]  min_interval,
  output logic              err
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  started_q, started_d;
  logic [CNT_W-1:0]  done_q, done_d;
  logic [CNT_W-1:0]  last_lat_q, last_lat_d;
  logic [CNT_W-1:0]  max_lat_q, max_lat_d;
  logic [CNT_W-1:0]  min_int_q, min_int_d;
  logic [CNT_W-1:0]  prev_acc_q, prev_acc_d;
  logic [CNT_W-1:0]  ts_q, ts_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hc_q, hc_d;
  logic              ap_start_q, ap_start_d;
  logic              busy_q, busy_d;
  logic              all_done_q, all_done_d;
  logic              err_q, err_d;

  logic              cont_w;
  logic              accept_w;
  logic              consume_w;
  logic              push_w;
  logic              pop_w;
  logic              fifo_full_w;
  logic              fifo_empty_w;
  logic [CNT_W-1:0]  fifo_dout_w;
  logic [CNT_W-1:0]  lat_w;
  logic [CNT_W-1:0]  intv_w;

  assign cont_w    = busy_q && (hc_q == '0);
  assign accept_w  = ap_start_q && ap_ready;
  assign consume_w = ap_done && cont_w;
  assign push_w    = accept_w && !fifo_full_w;
  // A done with nothing outstanding is flagged, never popped.
  assign pop_w     = consume_w && !fifo_empty_w;
  assign lat_w     = CNT_W'(latency_calc(LAT_CALC_W'(cyc_q), LAT_CALC_W'(fifo_dout_w)));
  assign intv_w    = cyc_q - prev_acc_q;

  ts_fifo #(
    .W     (CNT_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_ts_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_w),
    .pop   (pop_w),
    .din   (ts_q),
    .dout  (fifo_dout_w),
    .full  (fifo_full_w),
    .empty (fifo_empty_w)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q + CNT_ONE;
    num_d      = num_q;
    started_d  = started_q;
    done_d     = done_q;
    last_lat_d = last_lat_q;
    max_lat_d  = max_lat_q;
    min_int_d  = min_int_q;
    prev_acc_d = prev_acc_q;
    ts_d       = ts_q;
    hold_d     = hold_q;
    hc_d       = hc_q;
    busy_d     = busy_q;
    all_done_d = 1'b0;
    err_d      = err_q;
    ap_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_num_txn == '0) begin
            all_done_d = 1'b1;
          end else begin
            num_d      = cfg_num_txn;
            hold_d     = cfg_continue_hold;
            hc_d       = cfg_continue_hold;
            started_d  = '0;
            done_d     = '0;
            last_lat_d = '0;
            max_lat_d  = '0;
            min_int_d  = '1;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (accept_w) begin
          started_d  = started_q + CNT_ONE;
          prev_acc_d = cyc_q;
          if (started_q != '0 && intv_w < min_int_q) begin
            min_int_d = intv_w;
          end
        end

        // hc is re-armed right after every consume and only counts down
        // while the kernel holds ap_done, so the hold-off always starts at
        // the rising edge of the next ap_done.
        if (consume_w) begin
          hc_d = hold_q;
          if (fifo_empty_w) begin
            err_d = 1'b1;
          end else begin
            done_d     = done_q + CNT_ONE;
            last_lat_d = lat_w;
            if (lat_w > max_lat_q) begin
              max_lat_d = lat_w;
            end
          end
        end else if (ap_done && hc_q != '0) begin
          hc_d = hc_q - HOLD_ONE;
        end

        if (state_q == ST_RUN && started_d == num_q) begin
          state_d = ST_DRAIN;
        end
        if (state_q == ST_DRAIN && done_d == num_q) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          all_done_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (ap_ready && !ap_start_q) begin
      err_d = 1'b1;
    end

    // ap_start only falls after an acceptance (quota reached or FIFO now
    // full), so a pending request is never withdrawn.
    ap_start_d = (state_d == ST_RUN) && (started_d != num_d) &&
                 ((started_d - done_d) < MAX_CNT);

    // Timestamp is the cycle ap_start is first high for a transaction.
    if (ap_start_d && (!ap_start_q || accept_w)) begin
      ts_d = cyc_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      num_q      <= '0;
      started_q  <= '0;
      done_q     <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
      min_int_q  <= '1;
      prev_acc_q <= '0;
      ts_q       <= '0;
      hold_q     <= '0;
      hc_q       <= '0;
      ap_start_q <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      num_q      <= num_d;
      started_q  <= started_d;
      done_q     <= done_d;
      last_lat_q <= last_lat_d;
      max_lat_q  <= max_lat_d;
      min_int_q  <= min_int_d;
      prev_acc_q <= prev_acc_d;
      ts_q       <= ts_d;
      hold_q     <= hold_d;
      hc_q       <= hc_d;
      ap_start_q <= ap_start_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      err_q      <= err_d;
    end
  end

  assign ap_start     = ap_start_q;
  assign ap_continue  = cont_w;
  assign busy         = busy_q;
  assign all_done     = all_done_q;
  assign txn_started  = started_q;
  assign txn_done     = done_q;
  assign last_latency = last_lat_q;
  assign max_latency  = max_lat_q;
  assign min_interval = min_int_q;
  assign err          = err_q;

endmodule
